// File: rtl/frame_diff_scanner_pkg.sv
// rtl/frame_diff_scanner_pkg.sv - object codes and cell priority encoder shared by the scanner
package frame_pkg;

  localparam int CODE_BITS = 3;

  typedef logic [CODE_BITS-1:0] obj_code_t;

  localparam obj_code_t CODE_EMPTY  = 3'b000;
  localparam obj_code_t CODE_HEAD   = 3'b001;
  localparam obj_code_t CODE_BODY   = 3'b010;
  localparam obj_code_t CODE_APPLE  = 3'b011;
  localparam obj_code_t CODE_BORDER = 3'b100;

  // Border wins over everything, then head, body, apple.
  function automatic obj_code_t encode_cell(input logic border, input logic head,
                                            input logic body, input logic apple);
    obj_code_t c;
    c = CODE_EMPTY;
    if (border)     c = CODE_BORDER;
    else if (head)  c = CODE_HEAD;
    else if (body)  c = CODE_BODY;
    else if (apple) c = CODE_APPLE;
    return c;
  endfunction

endpackage

// File: rtl/frame_diff_scanner_if.sv
// rtl/frame_diff_scanner_if.sv - cell flag inputs and per-cell result outputs of the scanner
interface frame_diff_scanner_if #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(GRID_W * GRID_H + 1);

  logic              enable;
  logic              body;
  logic              head;
  logic              apple;
  logic              border;
  logic              force_redraw;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [XW-1:0]     cell_x;
  logic [YW-1:0]     cell_y;
  logic [CODE_W-1:0] obj_code;
  logic              diff;
  logic              out_valid;
  logic              frame_done;
  logic [CW-1:0]     diff_count;

  modport master (
    output enable, body, head, apple, border, force_redraw,
    input  x, y, cell_x, cell_y, obj_code, diff, out_valid, frame_done, diff_count
  );

  modport slave (
    input  enable, body, head, apple, border, force_redraw,
    output x, y, cell_x, cell_y, obj_code, diff, out_valid, frame_done, diff_count
  );

endinterface

// File: rtl/frame_diff_scanner_code_mem.sv
// rtl/frame_diff_scanner_code_mem.sv - previous-frame code store, read-before-write at one address
module frame_code_mem #(
  parameter int DEPTH  = 192,
  parameter int CODE_W = 3,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CODE_W-1:0] wdata,
  output logic [CODE_W-1:0] rdata
);

  logic [CODE_W-1:0] mem [DEPTH];

  // Combinational read returns the old value while the same address is being written.
  always_comb begin
    rdata = '0;
    if (int'(addr) < DEPTH) rdata = mem[addr];
  end

  // Reset empties every cell so the first frame compares against EMPTY.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(addr) < DEPTH)) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/frame_diff_scanner.sv
// rtl/frame_diff_scanner.sv - raster scan of the game grid reporting cells whose object code changed
module frame_diff_scanner #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CODE_W = 3
) (
  input logic                 clk,
  input logic                 nrst,
  frame_diff_scanner_if.slave bus
);
  import frame_pkg::*;

  localparam int NCELL = GRID_W * GRID_H;
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int CW    = $clog2(NCELL + 1);
  localparam int AW    = $clog2(NCELL);

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [XW-1:0]     cell_x_q;
  logic [YW-1:0]     cell_y_q;
  logic [CODE_W-1:0] obj_code_q;
  logic              diff_q;
  logic              out_valid_q;
  logic              frame_done_q;
  logic [CW-1:0]     diff_count_q;
  logic [CW-1:0]     accum_q;
  logic              redraw_pending;
  logic              redraw_active;

  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] prev_code;
  logic              first_cell;
  logic              last_cell;
  logic              redraw_now;
  logic              diff_now;
  logic [AW-1:0]     addr;

  // Per-cell decode: object code, frame position and whether the cell must be redrawn.
  always_comb begin
    code       = CODE_W'(encode_cell(bus.border, bus.head, bus.body, bus.apple));
    first_cell = (x_q == '0) && (y_q == '0);
    last_cell  = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));
    redraw_now = first_cell ? (redraw_pending | bus.force_redraw) : redraw_active;
    diff_now   = (code != prev_code) | redraw_now;
    addr       = AW'(y_q) * AW'(GRID_W) + AW'(x_q);
  end

  frame_code_mem #(
    .DEPTH  (NCELL),
    .CODE_W (CODE_W),
    .ADDR_W (AW)
  ) u_code_mem (
    .clk   (clk),
    .nrst  (nrst),
    .we    (bus.enable),
    .addr  (addr),
    .wdata (code),
    .rdata (prev_code)
  );

  // Raster scan position, advancing one cell per enabled cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (bus.enable) begin
      if (x_q == XW'(GRID_W - 1)) begin
        x_q <= '0;
        y_q <= (y_q == YW'(GRID_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Registered result of the cell sampled last cycle; data holds while disabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      obj_code_q   <= '0;
      diff_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= bus.enable;
      frame_done_q <= bus.enable & last_cell;
      if (bus.enable) begin
        cell_x_q   <= x_q;
        cell_y_q   <= y_q;
        obj_code_q <= code;
        diff_q     <= diff_now;
      end
    end
  end

  // Redraw requests are latched and only take effect from the next frame start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      redraw_pending <= 1'b0;
      redraw_active  <= 1'b0;
    end else if (bus.enable && first_cell) begin
      redraw_active  <= redraw_pending | bus.force_redraw;
      redraw_pending <= 1'b0;
    end else if (bus.force_redraw) begin
      redraw_pending <= 1'b1;
    end
  end

  // Changed-cell count; the published value updates only when a frame completes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      accum_q      <= '0;
      diff_count_q <= '0;
    end else if (bus.enable) begin
      accum_q <= first_cell ? CW'(diff_now) : accum_q + CW'(diff_now);
      if (last_cell) diff_count_q <= accum_q + CW'(diff_now);
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.cell_x     = cell_x_q;
  assign bus.cell_y     = cell_y_q;
  assign bus.obj_code   = obj_code_q;
  assign bus.diff       = diff_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.diff_count = diff_count_q;

endmodule
